// File: rtl/psum_input_fifo_pkg.sv
// Common PE parameter package: psum word and scratchpad geometry shared by
// the psum input FIFO and the PE's psum scratchpad.
package psum_input_fifo_pkg;

    // Width of one partial-sum word
    localparam int PSUM_DATA_WIDTH = 16;
    // Psum storage depth in words (power of two, multiple of PSUM_PAR_WRITE)
    localparam int PSUM_DEPTH      = 8;
    // Psum words delivered per upstream write beat
    localparam int PSUM_PAR_WRITE  = 2;

endpackage : psum_input_fifo_pkg

// File: rtl/psum_input_fifo.sv
// Psum input FIFO: accepts PAR_WRITE words per write beat, pops one word per
// read, and presents the head word show-ahead on dout. A write is accepted only
// if there is room before this edge's pop, so a pop never makes room for a
// write in the same cycle. A rejected write or an empty pop sets a sticky ovf.
module psum_input_fifo
    import psum_input_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
    parameter int DEPTH      = PSUM_DEPTH,
    parameter int PAR_WRITE  = PSUM_PAR_WRITE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wen,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
    input  logic                            ren,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            valid,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PAR_C   = CW'(PAR_WRITE);
    localparam logic [AW-1:0] PAR_A   = AW'(PAR_WRITE);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] free_space;
    logic          wr_ok;
    logic          rd_ok;

    // Accept/pop decisions and next-state, all from the pre-edge count
    always_comb begin
        free_space = DEPTH_C - count_q;
        wr_ok      = wen && (free_space >= PAR_C);
        rd_ok      = ren && (count_q != '0);

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (wr_ok) begin
            wptr_d = wptr_q + PAR_A;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + PAR_C;
            2'b01:   count_d = count_q - CW'(1);
            2'b11:   count_d = count_q + PAR_C - CW'(1);
            default: count_d = count_q;
        endcase
        if ((wen && !wr_ok) || (ren && !rd_ok)) begin
            ovf_d = 1'b1;
        end
    end

    // Control state: pointers, occupancy and sticky error, reset has priority
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage: all lanes of an accepted beat land in consecutive slots; a beat
    // never straddles the wrap because DEPTH is a multiple of PAR_WRITE
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                mem_q[wptr_q + AW'(i)] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Show-ahead head word and status flags derived from count only
    always_comb begin
        dout  = mem_q[rptr_q];
        empty = (count_q == '0);
        valid = !empty;
        full  = (free_space < PAR_C);
        count = count_q;
        ovf   = ovf_q;
    end

endmodule : psum_input_fifo

// File: tb/tb_psum_input_fifo.sv
// Directed bench for psum_input_fifo with default geometry (16b x 8, 2 per beat).
module tb_psum_input_fifo;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [31:0] din;
    logic        ren;
    logic [15:0] dout;
    logic        valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        ovf;

    int vecs;
    int errs;

    psum_input_fifo #(
        .DATA_WIDTH(16),
        .DEPTH     (8),
        .PAR_WRITE (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wen  (wen),
        .din  (din),
        .ren  (ren),
        .dout (dout),
        .valid(valid),
        .full (full),
        .empty(empty),
        .count(count),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wen = 1'b0; ren = 1'b0; din = '0;
        tick();
        rst = 1'b0;
    endtask

    // Write beats carrying words first..first+2*beats-1 (lane 0 = lower value)
    task automatic write_seq(input int first, input int beats);
        for (int b = 0; b < beats; b++) begin
            wen = 1'b1;
            din = {16'(first + 2*b + 1), 16'(first + 2*b)};
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
        vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty: got %b want 1", empty); end
        vecs++; if (full  !== 1'b0) begin errs++; $display("FAIL reset_full: got %b want 0", full); end
        vecs++; if (ovf   !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_basic();
        do_reset();
        wen = 1'b1; din = {16'h0002, 16'h0001};
        tick();
        wen = 1'b0;
        vecs++; if (count !== 4'd2) begin errs++; $display("FAIL basic_count: got %0d want 2", count); end
        vecs++; if (valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", valid); end
        vecs++; if (dout !== 16'h0001) begin errs++; $display("FAIL basic_head: got %h want 0001", dout); end
        ren = 1'b1;
        tick();
        ren = 1'b0;
        vecs++; if (dout !== 16'h0002) begin errs++; $display("FAIL basic_pop_head: got %h want 0002", dout); end
        vecs++; if (count !== 4'd1) begin errs++; $display("FAIL basic_pop_count: got %0d want 1", count); end
    endtask

    task automatic test_full_ovf();
        do_reset();
        write_seq(1, 4);
        vecs++; if (count !== 4'd8) begin errs++; $display("FAIL full_count: got %0d want 8", count); end
        vecs++; if (full !== 1'b1) begin errs++; $display("FAIL full_flag: got %b want 1", full); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL full_ovf_pre: got %b want 0", ovf); end
        wen = 1'b1; din = {16'hDEAD, 16'hBEEF};
        tick();
        wen = 1'b0;
        vecs++; if (count !== 4'd8) begin errs++; $display("FAIL full_rej_count: got %0d want 8", count); end
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL full_rej_ovf: got %b want 1", ovf); end
        ren = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            vecs++; if (dout !== 16'(k)) begin errs++; $display("FAIL full_drain_%0d: got %h want %h", k, dout, 16'(k)); end
            tick();
        end
        ren = 1'b0;
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL full_drain_empty: got %b want 1", empty); end
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL full_ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_simul();
        do_reset();
        write_seq(1, 3);
        vecs++; if (count !== 4'd6) begin errs++; $display("FAIL simul_pre_count: got %0d want 6", count); end
        // count=6: write and pop both taken
        wen = 1'b1; ren = 1'b1; din = {16'd8, 16'd7};
        tick();
        vecs++; if (count !== 4'd7) begin errs++; $display("FAIL simul6_count: got %0d want 7", count); end
        vecs++; if (dout !== 16'd2) begin errs++; $display("FAIL simul6_head: got %h want 0002", dout); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL simul6_ovf: got %b want 0", ovf); end
        // count=7: pop cannot make room, write rejected
        din = {16'h00AA, 16'h00BB};
        tick();
        wen = 1'b0; ren = 1'b0;
        vecs++; if (count !== 4'd6) begin errs++; $display("FAIL simul7_count: got %0d want 6", count); end
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL simul7_ovf: got %b want 1", ovf); end
        vecs++; if (full !== 1'b0) begin errs++; $display("FAIL simul7_full: got %b want 0", full); end
        ren = 1'b1;
        for (int k = 3; k <= 8; k++) begin
            vecs++; if (dout !== 16'(k)) begin errs++; $display("FAIL simul_drain_%0d: got %h want %h", k, dout, 16'(k)); end
            tick();
        end
        ren = 1'b0;
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL simul_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        do_reset();
        write_seq(1, 4);
        ren = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            vecs++; if (dout !== 16'(k)) begin errs++; $display("FAIL wrap_first_%0d: got %h want %h", k, dout, 16'(k)); end
            tick();
        end
        ren = 1'b0;
        vecs++; if (count !== 4'd2) begin errs++; $display("FAIL wrap_mid_count: got %0d want 2", count); end
        write_seq(9, 1);
        vecs++; if (count !== 4'd4) begin errs++; $display("FAIL wrap_after_count: got %0d want 4", count); end
        ren = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            vecs++; if (dout !== 16'(k)) begin errs++; $display("FAIL wrap_second_%0d: got %h want %h", k, dout, 16'(k)); end
            tick();
        end
        ren = 1'b0;
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL wrap_empty: got %b want 1", empty); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL wrap_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_empty_pop_and_rst_mid();
        do_reset();
        ren = 1'b1;
        tick();
        ren = 1'b0;
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL epop_count: got %0d want 0", count); end
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL epop_ovf: got %b want 1", ovf); end
        write_seq(1, 3);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        vecs++; if (count !== 4'd5) begin errs++; $display("FAIL rstmid_pre_count: got %0d want 5", count); end
        vecs++; if (dout !== 16'd2) begin errs++; $display("FAIL rstmid_pre_head: got %h want 0002", dout); end
        rst = 1'b1; wen = 1'b1; ren = 1'b1; din = {16'h0055, 16'h0066};
        tick();
        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL rstmid_count: got %0d want 0", count); end
        vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL rstmid_empty: got %b want 1", empty); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL rstmid_ovf: got %b want 0", ovf); end
        // Pointers back at 0: a fresh write must be the head
        write_seq(33, 1);
        vecs++; if (dout !== 16'd33) begin errs++; $display("FAIL rstmid_rewrite_head: got %h want 0021", dout); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst = 1'b1; wen = 1'b0; ren = 1'b0; din = '0;
        test_reset();
        test_basic();
        test_full_ovf();
        test_simul();
        test_wrap();
        test_empty_pop_and_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_psum_input_fifo
